// File: rtl/cdma_ll_fetch.sv
// Linked-list descriptor fetch engine: round-robin channel arbitration, one DMA
// read per descriptor, word assembly and tagged hand-off to the consumer.
//
// state  | meaning
// S_IDLE | waiting for a channel request; grant and latch ch/addr on request
// S_REQ  | DMA read request outstanding (or misaligned: ack and skip read)
// S_DATA | accepting returned beats until the last beat
// S_OUT  | descriptor presented until consumer takes it
module cdma_ll_fetch #(
  parameter int NCH        = 4,
  parameter int DESC_WORDS = 6,
  parameter int AW         = 32,
  parameter int DW         = 32
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic [NCH-1:0]                        ll_req,
  input  logic [NCH*AW-1:0]                     ll_addr,
  output logic [NCH-1:0]                        ll_ack,
  output logic                                  desc_vld,
  input  logic                                  desc_rdy,
  output logic [((NCH>1)?$clog2(NCH):1)-1:0]    desc_ch,
  output logic [DESC_WORDS*DW-1:0]              desc_data,
  output logic                                  desc_err,
  output logic                                  dma_r_req,
  input  logic                                  dma_r_ack,
  output logic [AW-1:0]                         dma_r_addr,
  output logic [15:0]                           dma_r_len,
  input  logic                                  dma_dvld,
  input  logic                                  dma_rd_last,
  input  logic [DW-1:0]                         dma_rdata,
  input  logic [DW/8-1:0]                       dma_rbe,
  output logic                                  dma_dack
);

  localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CNTW = $clog2(DESC_WORDS + 1);
  localparam int AL   = $clog2(DW / 8);
  localparam logic [15:0]     RD_LEN  = 16'(DESC_WORDS * DW / 8 - 1);
  localparam logic [CNTW-1:0] CNT_END = CNTW'(DESC_WORDS);
  localparam logic [CNTW-1:0] CNT_LST = CNTW'(DESC_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA, S_OUT} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           rr_q, ch_q, gnt_ch;
  logic [AW-1:0]           addr_q, gnt_addr;
  logic                    mis_q, err_q, gnt_found, beat_err;
  logic [CNTW-1:0]         cnt_q;
  logic [DESC_WORDS*DW-1:0] data_q;

  // first requester strictly after the last granted channel, wrapping
  always_comb begin
    int idx;
    gnt_found = 1'b0;
    gnt_ch    = '0;
    idx       = 0;
    for (int i = 1; i <= NCH; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= NCH) idx = idx - NCH;
      if (!gnt_found && ll_req[idx]) begin
        gnt_found = 1'b1;
        gnt_ch    = CW'(idx);
      end
    end
  end

  assign gnt_addr = ll_addr[int'(gnt_ch)*AW +: AW];

  assign beat_err = (dma_rbe != '1)
                 || (dma_rd_last && (cnt_q < CNT_LST))
                 || (cnt_q == CNT_END)
                 || ((cnt_q == CNT_LST) && !dma_rd_last);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    ll_ack    = '0;
    dma_r_req = 1'b0;
    dma_dack  = 1'b0;
    desc_vld  = 1'b0;
    case (state_q)
      S_IDLE: if (gnt_found) state_d = S_REQ;
      S_REQ: begin
        if (mis_q) begin
          ll_ack[ch_q] = 1'b1;
          state_d      = S_OUT;
        end else begin
          dma_r_req = 1'b1;
          if (dma_r_ack) begin
            ll_ack[ch_q] = 1'b1;
            state_d      = S_DATA;
          end
        end
      end
      S_DATA: begin
        dma_dack = 1'b1;
        if (dma_dvld && dma_rd_last) state_d = S_OUT;
      end
      S_OUT: begin
        desc_vld = 1'b1;
        if (desc_rdy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_q   <= CW'(NCH - 1);
      ch_q   <= '0;
      addr_q <= '0;
      mis_q  <= 1'b0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
      data_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (gnt_found) begin
          ch_q   <= gnt_ch;
          addr_q <= gnt_addr;
          mis_q  <= |gnt_addr[AL-1:0];
          err_q  <= 1'b0;
          cnt_q  <= '0;
          data_q <= '0;
        end
        S_REQ: begin
          if (mis_q) begin
            err_q <= 1'b1;
            rr_q  <= ch_q;
          end else if (dma_r_ack) begin
            rr_q  <= ch_q;
            cnt_q <= '0;
          end
        end
        S_DATA: if (dma_dvld) begin
          // beats past the descriptor length are drained but not stored
          if (cnt_q < CNT_END) begin
            data_q[int'(cnt_q)*DW +: DW] <= dma_rdata;
            cnt_q <= cnt_q + 1'b1;
          end
          if (beat_err) err_q <= 1'b1;
        end
        S_OUT: if (desc_rdy) err_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign dma_r_addr = dma_r_req ? addr_q : '0;
  assign dma_r_len  = dma_r_req ? RD_LEN : '0;
  assign desc_ch    = ch_q;
  assign desc_data  = data_q;
  assign desc_err   = err_q;

endmodule

// File: tb/tb_cdma_ll_fetch.sv
// Bench for cdma_ll_fetch: directed scenarios then randomized fetches checked
// against a round-robin / descriptor-assembly reference model.
module tb_cdma_ll_fetch;
  localparam int NCH = 4, DESC_WORDS = 6, AW = 32, DW = 32;
  localparam int DBW = DESC_WORDS * DW;
  localparam int W = 256;

  logic             clk, rstn;
  logic [NCH-1:0]   ll_req, ll_ack;
  logic [NCH*AW-1:0] ll_addr;
  logic             desc_vld, desc_rdy, desc_err;
  logic [1:0]       desc_ch;
  logic [DBW-1:0]   desc_data;
  logic             dma_r_req, dma_r_ack, dma_dvld, dma_rd_last, dma_dack;
  logic [AW-1:0]    dma_r_addr;
  logic [15:0]      dma_r_len;
  logic [DW-1:0]    dma_rdata;
  logic [DW/8-1:0]  dma_rbe;

  int checks = 0, failures = 0;
  logic [AW-1:0] addr_a [NCH];
  int rr_m;
  int ack_cnt [NCH] = '{default: 0};
  int ack_tot = 0;
  int got;
  int order [5] = '{0, 1, 2, 3, 0};

  assign ll_addr = {addr_a[3], addr_a[2], addr_a[1], addr_a[0]};

  cdma_ll_fetch #(.NCH(NCH), .DESC_WORDS(DESC_WORDS), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rstn(rstn), .ll_req(ll_req), .ll_addr(ll_addr), .ll_ack(ll_ack),
    .desc_vld(desc_vld), .desc_rdy(desc_rdy), .desc_ch(desc_ch), .desc_data(desc_data),
    .desc_err(desc_err), .dma_r_req(dma_r_req), .dma_r_ack(dma_r_ack),
    .dma_r_addr(dma_r_addr), .dma_r_len(dma_r_len), .dma_dvld(dma_dvld),
    .dma_rd_last(dma_rd_last), .dma_rdata(dma_rdata), .dma_rbe(dma_rbe), .dma_dack(dma_dack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk)
    for (int i = 0; i < NCH; i++)
      if (ll_ack[i] === 1'b1) begin
        ack_cnt[i] = ack_cnt[i] + 1;
        ack_tot    = ack_tot + 1;
      end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // next requester after the last granted channel
  function automatic int model_grant(input logic [NCH-1:0] m);
    for (int k = 1; k <= NCH; k++) begin
      int c;
      c = (rr_m + k) % NCH;
      if (m[c]) return c;
    end
    return 0;
  endfunction

  task automatic do_fetch(input logic [NCH-1:0] mask, input int nbeats, input int bad_idx,
                          input int ack_dly, input int hold, input bit early, output int got_ch);
    int ech, base_ch, base_tot;
    bit mis, eerr;
    logic [DBW-1:0] edata;
    logic [DW-1:0] w;
    ech      = model_grant(mask);
    base_ch  = ack_cnt[ech];
    base_tot = ack_tot;
    mis      = (addr_a[ech][1:0] != 2'b00);
    edata    = '0;
    eerr     = 1'b0;
    ll_req   = mask;
    tick();
    if (mis) begin
      chk("mis_no_rreq", W'(dma_r_req), W'(0));
      tick();
      eerr = 1'b1;
    end else begin
      chk("rreq", W'(dma_r_req), W'(1));
      chk("raddr", W'(dma_r_addr), W'(addr_a[ech]));
      chk("rlen", W'(dma_r_len), W'(DESC_WORDS * DW / 8 - 1));
      if (early) ll_req[ech] = 1'b0;
      for (int i = 0; i < ack_dly; i++) begin
        tick();
        chk("rreq_hold", W'(dma_r_req), W'(1));
        chk("raddr_hold", W'(dma_r_addr), W'(addr_a[ech]));
      end
      dma_r_ack = 1'b1;
      tick();
      dma_r_ack = 1'b0;
      chk("dack", W'(dma_dack), W'(1));
      for (int b = 0; b < nbeats; b++) begin
        repeat ($urandom_range(0, 2)) tick();
        w           = DW'($urandom);
        dma_dvld    = 1'b1;
        dma_rdata   = w;
        dma_rbe     = (b == bad_idx) ? 4'h7 : 4'hF;
        dma_rd_last = (b == nbeats - 1);
        if (b < DESC_WORDS) edata[b*DW +: DW] = w;
        tick();
        dma_dvld    = 1'b0;
        dma_rd_last = 1'b0;
        if (b < nbeats - 1) chk("no_early_exit", W'(desc_vld), W'(0));
      end
      eerr = (nbeats != DESC_WORDS) || (bad_idx >= 0 && bad_idx < nbeats);
    end
    chk("desc_vld", W'(desc_vld), W'(1));
    chk("desc_ch", W'(desc_ch), W'(ech));
    chk("desc_data", W'(desc_data), W'(edata));
    chk("desc_err", W'(desc_err), W'(eerr));
    chk("ack_once", W'(ack_cnt[ech] - base_ch), W'(1));
    chk("ack_total", W'(ack_tot - base_tot), W'(1));
    got_ch = int'(desc_ch);
    for (int h = 0; h < hold; h++) begin
      ll_req   = NCH'($urandom);
      dma_dvld = 1'($urandom_range(0, 1));
      tick();
      chk("hold_vld", W'(desc_vld), W'(1));
      chk("hold_data", W'(desc_data), W'(edata));
      chk("hold_err", W'(desc_err), W'(eerr));
      chk("hold_ch", W'(desc_ch), W'(ech));
      chk("hold_no_dack", W'(dma_dack), W'(0));
      chk("hold_no_rreq", W'(dma_r_req), W'(0));
    end
    dma_dvld = 1'b0;
    ll_req   = '0;
    desc_rdy = 1'b1;
    tick();
    desc_rdy = 1'b0;
    chk("vld_drop", W'(desc_vld), W'(0));
    chk("no_new_grant", W'(ack_tot - base_tot), W'(1));
    rr_m = ech;
  endtask

  initial begin
    rstn = 1'b0; ll_req = '0; desc_rdy = 1'b0; dma_r_ack = 1'b0;
    dma_dvld = 1'b0; dma_rd_last = 1'b0; dma_rdata = '0; dma_rbe = '0;
    for (int i = 0; i < NCH; i++) addr_a[i] = AW'(32'h100 * (i + 1));
    rr_m = NCH - 1;
    tick(); tick();
    chk("rst_vld", W'(desc_vld), W'(0));
    chk("rst_rreq", W'(dma_r_req), W'(0));
    chk("rst_data", W'(desc_data), W'(0));
    chk("rst_ack", W'(ll_ack), W'(0));
    #2 rstn = 1'b1;
    tick();

    // all channels requesting: strict rotation starting at ch0
    for (int n = 0; n < 5; n++) begin
      do_fetch(4'hF, DESC_WORDS, -1, n % 3, 0, 1'b0, got);
      chk("grant_order", W'(got), W'(order[n]));
    end

    addr_a[2] = 32'h1000;
    do_fetch(4'b0100, 6, -1, 1, 1, 1'b0, got);
    do_fetch(4'b1010, 4, -1, 0, 0, 1'b0, got);
    do_fetch(4'b0001, 8, -1, 2, 0, 1'b0, got);
    addr_a[1] = 32'h1002;
    do_fetch(4'b0010, 6, -1, 0, 10, 1'b0, got);
    addr_a[1] = 32'h1100;
    do_fetch(4'b0100, 6, 2, 0, 0, 1'b1, got);

    // reset in the middle of a data phase
    addr_a[3] = 32'h2000;
    ll_req = 4'b1000;
    tick();
    dma_r_ack = 1'b1;
    tick();
    dma_r_ack = 1'b0;
    ll_req = '0;
    for (int b = 0; b < 2; b++) begin
      dma_dvld = 1'b1; dma_rdata = DW'($urandom); dma_rbe = 4'hF;
      tick();
    end
    rstn = 1'b0;
    #1;
    chk("mrst_dack", W'(dma_dack), W'(0));
    chk("mrst_vld", W'(desc_vld), W'(0));
    chk("mrst_data", W'(desc_data), W'(0));
    chk("mrst_err", W'(desc_err), W'(0));
    chk("mrst_ch", W'(desc_ch), W'(0));
    chk("mrst_raddr", W'(dma_r_addr), W'(0));
    dma_dvld = 1'b0;
    #1 rstn = 1'b1;
    rr_m = NCH - 1;
    do_fetch(4'hF, 6, -1, 0, 0, 1'b0, got);
    chk("post_rst_ch0", W'(got), W'(0));

    for (int n = 0; n < 16; n++) begin
      logic [NCH-1:0] m;
      int nb, bad;
      for (int i = 0; i < NCH; i++) begin
        addr_a[i] = AW'($urandom) & ~AW'(3);
        if ($urandom_range(0, 5) == 0) addr_a[i] = addr_a[i] | AW'($urandom_range(1, 3));
      end
      m   = NCH'($urandom_range(1, 15));
      nb  = ($urandom_range(0, 1) == 1) ? DESC_WORDS : $urandom_range(3, 8);
      bad = ($urandom_range(0, 4) == 0) ? $urandom_range(0, nb - 1) : -1;
      do_fetch(m, nb, bad, $urandom_range(0, 3), $urandom_range(0, 3),
               1'($urandom_range(0, 3) == 0), got);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
